note_oscillator: RTL

- Next-generation tone source for the synth datapath: note selection plus divider lookup plus the divide-by-N square-wave counter, in one block.
- Adds octave shifting (divider right-shift), glitch-free note changes applied only at period boundaries, and a registered playing/active-note status.
- Sits between keypad/sequencer decode (keycode, sound_series) and the audio output / PWM stage.

---
 rtl/note_oscillator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/note_oscillator.sv
// Square-wave tone source: key/sequencer request decode, divider LUT with octave shift,
// and a divide-by-N period counter whose note changes land only on period boundaries.
module note_oscillator #(
    parameter int CNT_W = 16,
    parameter int OCT_W = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             is_FPGA,
    input  logic [3:0]       keycode,
    input  logic [3:0]       sound_series,
    input  logic [OCT_W-1:0] octave,
    output logic             wave,
    output logic [CNT_W-1:0] divider,
    output logic [3:0]       note_active,
    output logic             playing,
    output logic             period_tick
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] divider_q, divider_d;
    logic [3:0]       note_q, note_d;
    logic             wave_q, wave_d;

    logic [3:0]       req_raw;
    logic [3:0]       req;
    logic [15:0]      lut_val;
    logic [CNT_W-1:0] tgt;
    logic             last;
    logic             tick;

    function automatic logic [15:0] lut_div(input logic [3:0] code, input logic fpga);
        logic [15:0] v;
        v = 16'd0;
        if (!fpga) begin
            case (code)
                4'd1:  v = 16'd38223;
                4'd2:  v = 16'd36077;
                4'd3:  v = 16'd34052;
                4'd4:  v = 16'd32141;
                4'd5:  v = 16'd30337;
                4'd6:  v = 16'd28635;
                4'd7:  v = 16'd27027;
                4'd8:  v = 16'd25511;
                4'd9:  v = 16'd24079;
                4'd10: v = 16'd22727;
                4'd11: v = 16'd21452;
                4'd12: v = 16'd20248;
                4'd13: v = 16'd19111;
                default: v = 16'd0;
            endcase
        end else begin
            case (code)
                4'd1:  v = 16'd45868;
                4'd2:  v = 16'd43292;
                4'd3:  v = 16'd40862;
                4'd4:  v = 16'd38569;
                4'd5:  v = 16'd36404;
                4'd6:  v = 16'd34362;
                4'd7:  v = 16'd32432;
                4'd8:  v = 16'd30613;
                4'd9:  v = 16'd28895;
                4'd10: v = 16'd27272;
                4'd11: v = 16'd25742;
                4'd12: v = 16'd24298;
                4'd13: v = 16'd22933;
                default: v = 16'd0;
            endcase
        end
        return v;
    endfunction

    // Both sources active at once is a conflict and decodes to silence.
    always_comb begin
        req_raw = 4'd0;
        if (en) begin
            if (keycode != 4'd0 && sound_series == 4'd0) begin
                req_raw = keycode;
            end else if (sound_series != 4'd0 && keycode == 4'd0) begin
                req_raw = sound_series;
            end
        end
        if (req_raw > 4'd13) begin
            req_raw = 4'd0;
        end
    end

    assign lut_val = lut_div(req_raw, is_FPGA);
    assign tgt     = CNT_W'(lut_val) >> octave;
    assign req     = (tgt < TWO) ? 4'd0 : req_raw;
    assign last    = (count_q == divider_q - ONE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            divider_q <= '0;
            note_q    <= 4'd0;
            wave_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            divider_q <= divider_d;
            note_q    <= note_d;
            wave_q    <= wave_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (req != 4'd0) state_d = S_RUN;
                S_RUN:   if (last && req == 4'd0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Divider and note are only reloaded at IDLE->RUN or at the period wrap.
    always_comb begin
        count_d   = count_q;
        divider_d = divider_q;
        note_d    = note_q;
        tick      = 1'b0;
        if (!en) begin
            count_d   = '0;
            divider_d = '0;
            note_d    = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    count_d = '0;
                    if (req != 4'd0) begin
                        divider_d = tgt;
                        note_d    = req;
                    end else begin
                        divider_d = '0;
                        note_d    = 4'd0;
                    end
                end
                S_RUN: begin
                    if (last) begin
                        tick    = 1'b1;
                        count_d = '0;
                        if (req == 4'd0) begin
                            divider_d = '0;
                            note_d    = 4'd0;
                        end else begin
                            divider_d = tgt;
                            note_d    = req;
                        end
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                default: begin
                    count_d   = '0;
                    divider_d = '0;
                    note_d    = 4'd0;
                end
            endcase
        end
        wave_d = (state_d == S_RUN) && (count_d < (divider_d >> 1));
    end

    assign wave        = wave_q;
    assign divider     = divider_q;
    assign note_active = note_q;
    assign playing     = (state_q == S_RUN);
    assign period_tick = tick;

endmodule
